video_sync_v: RTL and testbench

VIDEO_SYNC_V -- requirements
Module: video_sync_v

---
 rtl/video_pkg.sv | 54 +++++
 rtl/video_int_stretch.sv | 65 ++++++
 rtl/video_sync_v.sv | 173 +++++++++++++++++
 tb/tb_video_sync_v.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg -- shared constants and types for the vertical video timing block.
// Holds the per-raster frame periods (in lines), the vertical blank / sync /
// pixel-window line numbers for both window sizes, the INT position and
// length, the raster mode encoding, and a helper that maps a raster mode to
// its frame period.
package video_pkg;

  // Raster select encoding as presented on modes_raster.
  typedef enum logic [1:0] {
    RASTER_PENT = 2'b00,
    RASTER_60HZ = 2'b01,
    RASTER_48K  = 2'b10,
    RASTER_128K = 2'b11
  } raster_e;

  // Frame period in lines for each raster.
  localparam logic [8:0] PERIOD_PENT = 9'd320;
  localparam logic [8:0] PERIOD_60HZ = 9'd262;
  localparam logic [8:0] PERIOD_48K  = 9'd312;
  localparam logic [8:0] PERIOD_128K = 9'd311;

  // Vertical blank starts on line 0 and ends on VBLNK_END.
  localparam logic [8:0] VBLNK_BEG = 9'd0;
  localparam logic [8:0] VBLNK_END = 9'd32;

  // Vertical sync covers lines VSYNC_BEG .. VSYNC_END-1.
  localparam logic [8:0] VSYNC_BEG = 9'd8;
  localparam logic [8:0] VSYNC_END = 9'd12;

  // Pixel window: 192 lines for the 256x192 screen, 240 for 320x240.
  localparam logic [8:0] VPIX_BEG_PENT = 9'd80;
  localparam logic [8:0] VPIX_END_PENT = 9'd272;
  localparam logic [8:0] VPIX_BEG_ATM  = 9'd56;
  localparam logic [8:0] VPIX_END_ATM  = 9'd296;

  // INT is raised on this line and held for INT_LEN cend strobes.
  localparam logic [8:0] VINT_BEG     = 9'd0;
  localparam int         INT_LEN      = 64;
  localparam logic [5:0] INT_CNT_LAST = 6'(INT_LEN - 1);

  // Frame period (in lines) of a raster mode.
  function automatic logic [8:0] raster_period(input raster_e mode);
    logic [8:0] p;
    case (mode)
      RASTER_PENT: p = PERIOD_PENT;
      RASTER_60HZ: p = PERIOD_60HZ;
      RASTER_48K:  p = PERIOD_48K;
      RASTER_128K: p = PERIOD_128K;
      default:     p = PERIOD_PENT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/video_int_stretch.sv
// video_int_stretch -- Z80 INT pulse generator.
// A trigger (hint_start while vcount is on the INT line) pulls int_n low on
// the next clk. While low, cend strobes are counted and int_n returns high
// after exactly INT_LEN of them. A new trigger while low restarts the count.
// The cend of the trigger cycle itself is not counted, because int_n is not
// low yet in that cycle.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   cend        video-cycle strobe
//   hint_start  horizontal INT position strobe
//   vcount      current line (value before any increment this cycle)
//   int_n       registered INT output, active low
module video_int_stretch
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hint_start,
  input  logic [8:0] vcount,
  output logic       int_n
);

  logic       int_n_r;
  logic       int_n_nxt_s;
  logic [5:0] cnt_r;
  logic [5:0] cnt_nxt_s;
  logic       trig_s;

  // Trigger detection and pulse length counting.
  always_comb begin
    trig_s      = hint_start && (vcount == VINT_BEG);
    int_n_nxt_s = int_n_r;
    cnt_nxt_s   = cnt_r;
    if (trig_s) begin
      int_n_nxt_s = 1'b0;
      cnt_nxt_s   = 6'd0;
    end else if (!int_n_r && cend) begin
      if (cnt_r == INT_CNT_LAST) begin
        int_n_nxt_s = 1'b1;
        cnt_nxt_s   = 6'd0;
      end else begin
        int_n_nxt_s = 1'b0;
        cnt_nxt_s   = cnt_r + 6'd1;
      end
    end else begin
      int_n_nxt_s = int_n_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // INT state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_n_r <= 1'b1;
      cnt_r   <= 6'd0;
    end else begin
      int_n_r <= int_n_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign int_n = int_n_r;

endmodule

// File: rtl/video_sync_v.sv
// video_sync_v -- vertical video timing: line counter, vertical blank, sync,
// pixel window, frame strobe, Z80 INT and attribute flash phase.
// The line counter advances on hsync_start and wraps when it reaches the
// last line of the selected raster (>= compare, so a raster change to a
// shorter frame wraps on the next line instead of running away).
// Vertical flags are set/cleared on the hsync_start that loads the boundary
// line. All outputs are registered.
// Optional feature: define VIDEO_FLASH_EN to add a 5-bit frame counter whose
// bit 4 drives flash; otherwise flash is constant 0.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   cend              7 MHz video-cycle strobe
//   hsync_start       line strobe (once per line)
//   hint_start        horizontal INT position strobe
//   modes_raster      raster select (00 Pentagon, 01 60 Hz, 10 48k, 11 128k)
//   mode_atm_n_pent   1: 320x240 window, 0: 256x192 window
//   vblank, vsync     vertical blank / sync
//   vpix              vertical pixel window
//   frame_start       one-clk strobe when line 0 is loaded
//   int_n             Z80 INT, active low
//   flash             attribute flash phase
//   vcount            current line number
module video_sync_v
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       hsync_start,
  input  logic       hint_start,
  input  logic [1:0] modes_raster,
  input  logic       mode_atm_n_pent,
  output logic       vblank,
  output logic       vsync,
  output logic       vpix,
  output logic       frame_start,
  output logic       int_n,
  output logic       flash,
  output logic [8:0] vcount
);

  logic [8:0] vcount_r;
  logic       vblank_r;
  logic       vsync_r;
  logic       vpix_r;
  logic       frame_start_r;

  logic [8:0] period_s;
  logic       wrap_s;
  logic [8:0] next_line_s;
  logic [8:0] vpix_beg_s;
  logic [8:0] vpix_end_s;
  logic       vblank_nxt_s;
  logic       vsync_nxt_s;
  logic       vpix_nxt_s;
  logic       frame_start_nxt_s;

  // Next line number and vertical flag updates for the coming hsync_start.
  always_comb begin
    period_s     = raster_period(raster_e'(modes_raster));
    wrap_s       = (vcount_r >= (period_s - 9'd1));
    next_line_s  = 9'd0;
    vpix_beg_s   = VPIX_BEG_PENT;
    vpix_end_s   = VPIX_END_PENT;
    vblank_nxt_s = vblank_r;
    vsync_nxt_s  = vsync_r;
    vpix_nxt_s   = vpix_r;

    if (wrap_s) begin
      next_line_s = 9'd0;
    end else begin
      next_line_s = vcount_r + 9'd1;
    end

    // Window size is taken at each strobe, so a change affects the next edge.
    if (mode_atm_n_pent) begin
      vpix_beg_s = VPIX_BEG_ATM;
      vpix_end_s = VPIX_END_ATM;
    end else begin
      vpix_beg_s = VPIX_BEG_PENT;
      vpix_end_s = VPIX_END_PENT;
    end

    frame_start_nxt_s = hsync_start && wrap_s;

    if (hsync_start) begin
      if (next_line_s == VBLNK_BEG) begin
        vblank_nxt_s = 1'b1;
      end else if (next_line_s == VBLNK_END) begin
        vblank_nxt_s = 1'b0;
      end else begin
        vblank_nxt_s = vblank_r;
      end

      if (next_line_s == VSYNC_BEG) begin
        vsync_nxt_s = 1'b1;
      end else if (next_line_s == VSYNC_END) begin
        vsync_nxt_s = 1'b0;
      end else begin
        vsync_nxt_s = vsync_r;
      end

      if (next_line_s == vpix_beg_s) begin
        vpix_nxt_s = 1'b1;
      end else if (next_line_s == vpix_end_s) begin
        vpix_nxt_s = 1'b0;
      end else begin
        vpix_nxt_s = vpix_r;
      end
    end else begin
      vblank_nxt_s = vblank_r;
      vsync_nxt_s  = vsync_r;
      vpix_nxt_s   = vpix_r;
    end
  end

  // Line counter and vertical flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_r      <= 9'd0;
      vblank_r      <= 1'b0;
      vsync_r       <= 1'b0;
      vpix_r        <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      if (hsync_start) begin
        vcount_r <= next_line_s;
      end else begin
        vcount_r <= vcount_r;
      end
      vblank_r      <= vblank_nxt_s;
      vsync_r       <= vsync_nxt_s;
      vpix_r        <= vpix_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  // INT uses the line number before this cycle's increment.
  video_int_stretch u_int_stretch (
    .clk        (clk),
    .rst        (rst),
    .cend       (cend),
    .hint_start (hint_start),
    .vcount     (vcount_r),
    .int_n      (int_n)
  );

`ifdef VIDEO_FLASH_EN
  logic [4:0] frame_cnt_r;

  // Frame counter; bit 4 toggles every 16 frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 5'd0;
    end else if (frame_start_r) begin
      frame_cnt_r <= frame_cnt_r + 5'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign flash = frame_cnt_r[4];
`else
  assign flash = 1'b0;
`endif

  assign vcount      = vcount_r;
  assign vblank      = vblank_r;
  assign vsync       = vsync_r;
  assign vpix        = vpix_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_video_sync_v.sv
// tb_video_sync_v -- self-checking bench for video_sync_v. A behavioural
// model (line number arithmetic, window intervals, cend tallies since the
// last INT trigger, frame tally) is advanced alongside the DUT at every clk.
module tb_video_sync_v;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cend = 1'b0;
  logic       hsync_start = 1'b0;
  logic       hint_start = 1'b0;
  logic [1:0] modes_raster = 2'b00;
  logic       mode_atm_n_pent = 1'b0;
  logic       vblank, vsync, vpix, frame_start, int_n, flash;
  logic [8:0] vcount;

  int tests = 0;
  int fails = 0;

  // Model state
  int m_v = 0;          // current line
  bit m_seen0 = 0;      // line 0 loaded since reset
  bit m_fs = 0;         // frame_start expected
  bit armed = 0;        // INT triggered since reset
  int cend_total = 0;   // cend strobes seen (not in reset)
  int mark = 0;         // cend_total right after last trigger
  int wraps = 0;        // frames started since reset
  bit m_flash = 0;

  video_sync_v dut (
    .clk             (clk),
    .rst             (rst),
    .cend            (cend),
    .hsync_start     (hsync_start),
    .hint_start      (hint_start),
    .modes_raster    (modes_raster),
    .mode_atm_n_pent (mode_atm_n_pent),
    .vblank          (vblank),
    .vsync           (vsync),
    .vpix            (vpix),
    .frame_start     (frame_start),
    .int_n           (int_n),
    .flash           (flash),
    .vcount          (vcount)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input logic [1:0] m);
    int p;
    case (m)
      2'b00: p = 320;
      2'b01: p = 262;
      2'b10: p = 312;
      default: p = 311;
    endcase
    return p;
  endfunction

  function automatic bit exp_vblank();
    return m_seen0 && (m_v < 32);
  endfunction

  function automatic bit exp_vsync();
    return m_seen0 && (m_v >= 8) && (m_v < 12);
  endfunction

  function automatic bit exp_vpix();
    if (mode_atm_n_pent) return m_seen0 && (m_v >= 56) && (m_v < 296);
    else                 return m_seen0 && (m_v >= 80) && (m_v < 272);
  endfunction

  function automatic bit exp_int_n();
    return !(armed && ((cend_total - mark) < 64));
  endfunction

  // One clk: drive inputs, advance model at the edge, release inputs #1 later.
  task automatic step(input bit c, input bit hs, input bit hi);
    bit trig, wrap;
    cend = c; hsync_start = hs; hint_start = hi;
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_seen0 = 0; m_fs = 0; armed = 0; wraps = 0; m_flash = 0;
    end else begin
`ifdef VIDEO_FLASH_EN
      m_flash = ((wraps / 16) % 2) == 1;
`else
      m_flash = 0;
`endif
      trig = hi && (m_v == 0);
      if (c) cend_total++;
      if (trig) begin armed = 1; mark = cend_total; end
      wrap = hs && (m_v >= period_of(modes_raster) - 1);
      m_fs = wrap;
      if (hs) m_v = wrap ? 0 : m_v + 1;
      if (wrap) begin m_seen0 = 1; wraps++; end
    end
    #1;
    cend = 1'b0; hsync_start = 1'b0; hint_start = 1'b0;
  endtask

  task automatic idle_cycle(input bit allow_hint);
    bit c, h;
    c = 1'($urandom_range(0, 1));
    h = allow_hint && !c && ($urandom_range(0, 7) == 0);
    step(c, 1'b0, h);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'($urandom_range(0,1)), 1'b1, 1'b1);
    step(1'($urandom_range(0,1)), 1'b1, 1'b1);
    tests++; if (vcount !== 9'd0) begin fails++; $display("FAIL reset_vcount got %0d want 0", vcount); end
    tests++; if (vblank !== 1'b0) begin fails++; $display("FAIL reset_vblank got %b want 0", vblank); end
    tests++; if (vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync got %b want 0", vsync); end
    tests++; if (vpix !== 1'b0) begin fails++; $display("FAIL reset_vpix got %b want 0", vpix); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL reset_int_n got %b want 1", int_n); end
    tests++; if (flash !== 1'b0) begin fails++; $display("FAIL reset_flash got %b want 0", flash); end
    rst = 1'b0;
  endtask

  task automatic test_first_line();
    modes_raster = 2'b10; mode_atm_n_pent = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    tests++; if (vcount !== 9'd1) begin fails++; $display("FAIL first_line vcount got %0d want 1", vcount); end
  endtask

  task automatic test_wrap();
    int pulses = 0, last_idx = -1, prev_v;
    for (int n = 1; n <= 2 * 312 + 8; n++) begin
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        idle_cycle(1'b0);
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL wrap_fs_width got %b want 0", frame_start); end
      end
      prev_v = int'(vcount);
      step(1'b1, 1'b1, 1'b0);
      tests++; if (vcount !== m_v[8:0] || frame_start !== m_fs) begin
        fails++; $display("FAIL wrap_step vcount/fs got %0d/%b want %0d/%b", vcount, frame_start, m_v, m_fs);
      end
      if (frame_start === 1'b1) begin
        pulses++;
        tests++; if (prev_v != 311) begin fails++; $display("FAIL wrap_from got %0d want 311", prev_v); end
        if (last_idx >= 0) begin
          tests++; if (n - last_idx != 312) begin fails++; $display("FAIL wrap_interval got %0d want 312", n - last_idx); end
        end
        last_idx = n;
      end
    end
    tests++; if (pulses != 2) begin fails++; $display("FAIL wrap_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_windows();
    int nb, ns, np, guard;
    modes_raster = 2'b00; mode_atm_n_pent = 1'b0;
    guard = 0;
    while (m_v != 0 && guard < 400) begin step(1'b1, 1'b1, 1'b0); guard++; end
    tests++; if (m_v != 0) begin fails++; $display("FAIL windows_sync timeout line %0d want 0", m_v); end
    for (int f = 0; f < 2; f++) begin
      mode_atm_n_pent = f[0];
      nb = 0; ns = 0; np = 0;
      for (int l = 0; l < 320; l++) begin
        for (int g = 0; g < $urandom_range(0, 2); g++) begin
          idle_cycle(1'b1);
          tests++; if (int_n !== exp_int_n()) begin fails++; $display("FAIL windows_int_n got %b want %b", int_n, exp_int_n()); end
        end
        step(1'b1, 1'b1, 1'b0);
        tests++; if (vblank !== exp_vblank() || vsync !== exp_vsync() || vpix !== exp_vpix() || vcount !== m_v[8:0]) begin
          fails++; $display("FAIL windows_line %0d got bl/sy/px=%b%b%b v=%0d want %b%b%b v=%0d",
                            l, vblank, vsync, vpix, vcount, exp_vblank(), exp_vsync(), exp_vpix(), m_v);
        end
        if (vblank === 1'b1) nb++;
        if (vsync === 1'b1) ns++;
        if (vpix === 1'b1) np++;
      end
      tests++; if (nb != 32) begin fails++; $display("FAIL windows_vblank_lines got %0d want 32", nb); end
      tests++; if (ns != 4) begin fails++; $display("FAIL windows_vsync_lines got %0d want 4", ns); end
      tests++; if (np != (f == 0 ? 192 : 240)) begin
        fails++; $display("FAIL windows_vpix_lines got %0d want %0d", np, (f == 0 ? 192 : 240));
      end
    end
    mode_atm_n_pent = 1'b0;
  endtask

  // Count cend strobes until int_n rises; returns the count (bounded).
  task automatic count_int(output int n);
    n = 0;
    for (int i = 0; i < 400 && int_n === 1'b0; i++) begin
      step(i[0], 1'b0, 1'b0);
      if (i[0]) n++;
      tests++; if (int_n !== exp_int_n()) begin fails++; $display("FAIL int_track got %b want %b", int_n, exp_int_n()); end
    end
  endtask

  task automatic goto_line(input int target);
    int guard = 0;
    while (m_v != target && guard < 400) begin step(1'b1, 1'b1, 1'b0); guard++; end
    tests++; if (vcount !== 9'(target)) begin fails++; $display("FAIL goto_line got %0d want %0d", vcount, target); end
  endtask

  task automatic test_int();
    int n;
    modes_raster = 2'b00;
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b0);
    goto_line(0);
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL int_idle got %b want 1", int_n); end
    step(1'b0, 1'b0, 1'b1);
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL int_assert got %b want 0", int_n); end
    count_int(n);
    tests++; if (int_n !== 1'b1 || n != 64) begin fails++; $display("FAIL int_len got int_n=%b cends=%0d want 1/64", int_n, n); end
    // hint off the INT line must not trigger
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL int_wrong_line got %b want 1", int_n); end
    goto_line(0);
    // retrigger after 40 cends
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    tests++; if (int_n !== 1'b0) begin fails++; $display("FAIL int_at40 got %b want 0", int_n); end
    step(1'b0, 1'b0, 1'b1);
    count_int(n);
    tests++; if (int_n !== 1'b1 || n != 64) begin fails++; $display("FAIL int_retrig got int_n=%b cends=%0d want 1/64", int_n, n); end
    // hsync and hint together: compare uses the pre-increment line
    goto_line(0);
    step(1'b0, 1'b1, 1'b1);
    tests++; if (int_n !== 1'b0 || vcount !== 9'd1) begin fails++; $display("FAIL int_with_hsync got int_n=%b v=%0d want 0/1", int_n, vcount); end
    count_int(n);
    tests++; if (n != 64) begin fails++; $display("FAIL int_with_hsync_len got %0d want 64", n); end
  endtask

  task automatic test_mode_change();
    modes_raster = 2'b00;
    goto_line(300);
    modes_raster = 2'b01;
    step(1'b1, 1'b1, 1'b0);
    tests++; if (vcount !== 9'd0 || frame_start !== 1'b1) begin
      fails++; $display("FAIL mode_change got v=%0d fs=%b want 0/1", vcount, frame_start);
    end
    step(1'b0, 1'b0, 1'b0);
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL mode_change_fs_width got %b want 0", frame_start); end
    modes_raster = 2'b00;
  endtask

  task automatic test_reset_mid();
    modes_raster = 2'b00;
    goto_line(0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b0);
    tests++; if (int_n !== 1'b0 || vcount !== 9'd150) begin
      fails++; $display("FAIL reset_mid_setup got int_n=%b v=%0d want 0/150", int_n, vcount);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    tests++; if (int_n !== 1'b1) begin fails++; $display("FAIL reset_mid_int_n got %b want 1", int_n); end
    tests++; if ({vcount, vblank, vsync, vpix, frame_start, flash} !== 14'd0) begin
      fails++; $display("FAIL reset_mid_outputs got v=%0d bl=%b sy=%b px=%b fs=%b fl=%b want all 0",
                        vcount, vblank, vsync, vpix, frame_start, flash);
    end
    rst = 1'b0;
  endtask

  task automatic test_flash();
    int guard;
    bit want;
    rst = 1'b1; step(1'b0, 1'b0, 1'b0); rst = 1'b0;
    modes_raster = 2'b10;
    for (int f = 1; f <= 32; f++) begin
      guard = 0;
      do begin step(1'b1, 1'b1, 1'b0); guard++; end while (!m_fs && guard < 400);
      step(1'b0, 1'b0, 1'b0);
      tests++; if (flash !== m_flash) begin fails++; $display("FAIL flash_frame %0d got %b want %b", f, flash, m_flash); end
`ifdef VIDEO_FLASH_EN
      want = (f == 16);
`else
      want = 1'b0;
`endif
      if (f == 16 || f == 32) begin
        tests++; if (flash !== want) begin fails++; $display("FAIL flash_at_%0d got %b want %b", f, flash, want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_wrap();
    test_windows();
    test_int();
    test_mode_change();
    test_reset_mid();
    test_flash();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
